digit_receiver: RTL and testbench

- Receiving end of the 3-bit digit link: samples the data lines in0..in2 while the controlIn strobe is high.
- Qualifies the strobe length and rejects glitches, unstable data and code 7.
- Presents each accepted digit with a one-cycle valid pulse.
- Sits on the Arduino-side or loopback FPGA path, feeding the keylock code-entry logic.

---
 rtl/keylock_pkg.sv | 8 +
 rtl/input_synchronizer.sv | 25 ++
 rtl/digit_receiver.sv | 125 ++++++++++++
 tb/tb_digit_receiver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// Types and constants shared by the keylock digit transmitter and receiver.
package keylock_pkg;
   typedef enum logic [1:0] {IDLE, QUALIFY, HOLD, DRAIN} rx_state_t;

   localparam int DIGIT_W = 3;
   localparam logic [DIGIT_W-1:0] CODE_INVALID = 3'd7;
   localparam int HOLD_TIME_DFLT = 1200000;
endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for a bus of independent asynchronous inputs.
module input_synchronizer #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             hwclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_sync [STAGES];

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= d;
         for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

// File: rtl/digit_receiver.sv
// Receives 3-bit digits framed by a held strobe; qualifies strobe length and
// data stability, then pulses valid (accepted digit) or err (rejected frame).
module digit_receiver
   import keylock_pkg::*;
#(
   parameter int HOLD_TIME = HOLD_TIME_DFLT,
   parameter int MIN_HOLD  = HOLD_TIME / 2,
   parameter int MAX_HOLD  = HOLD_TIME * 2,
   parameter int CNT_W     = 32
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       controlIn,
   output logic [3:0] num,
   output logic       valid,
   output logic       err,
   output logic       busy
);

   localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_HOLD);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= C_MAX) ? C_MAX : v + 1'b1;
   endfunction

   logic [3:0]         w_sync_q;
   logic [DIGIT_W-1:0] w_dat;
   logic               w_ctl;
   logic               w_start;
   logic               w_diff;

   rx_state_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_unstable;
   logic [DIGIT_W-1:0] r_cap;

   input_synchronizer #(
      .WIDTH  (4),
      .STAGES (2)
   ) u_sync (
      .hwclk (hwclk),
      .rst   (rst),
      .d     ({in2, in1, in0, controlIn}),
      .q     (w_sync_q)
   );

   assign w_dat   = w_sync_q[3:1];
   assign w_ctl   = w_sync_q[0];
   assign w_start = (r_state == IDLE) && w_ctl;
   assign w_diff  = (w_dat != r_cap);

   // Captured digit is pure data: only meaningful once a frame has started.
   always_ff @(posedge hwclk) begin
      if (w_start) r_cap <= w_dat;
   end

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_unstable <= 1'b0;
         num        <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ctl) begin
                  r_state    <= QUALIFY;
                  r_cnt      <= CNT_W'(1);
                  r_unstable <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            QUALIFY: begin
               if (!w_ctl) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
                  if (w_diff) r_unstable <= 1'b1;
                  if (r_cnt == C_MIN_LAST) r_state <= HOLD;
               end
            end
            HOLD: begin
               // Timeout is checked first so it wins over a simultaneous strobe drop.
               if (r_cnt >= C_MAX) begin
                  err     <= 1'b1;
                  r_state <= DRAIN;
               end else if (!w_ctl) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
                  if (r_unstable || (r_cap == CODE_INVALID)) begin
                     err <= 1'b1;
                  end else begin
                     num   <= {1'b0, r_cap};
                     valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= sat_inc(r_cnt);
                  if (w_diff) r_unstable <= 1'b1;
               end
            end
            DRAIN: begin
               if (!w_ctl) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_receiver.sv
// Bench for digit_receiver: frame-level outcome model checked every cycle.
module tb_digit_receiver;
   localparam int HT   = 20;
   localparam int MINH = 10;
   localparam int MAXH = 40;
   localparam int N    = 2048;

   logic       hwclk = 1'b0;
   logic       rst = 1'b1;
   logic       in0 = 1'b0;
   logic       in1 = 1'b0;
   logic       in2 = 1'b0;
   logic       controlIn = 1'b0;
   logic [3:0] num;
   logic       valid;
   logic       err;
   logic       busy;

   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   bit         chk_en = 1'b0;
   bit         exp_valid [N];
   bit         exp_err   [N];
   bit         exp_busy  [N];
   int         num_set   [N];
   logic [3:0] model_num = 4'd0;

   digit_receiver #(
      .HOLD_TIME (HT),
      .MIN_HOLD  (MINH),
      .MAX_HOLD  (MAXH),
      .CNT_W     (32)
   ) dut (
      .hwclk     (hwclk),
      .rst       (rst),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .controlIn (controlIn),
      .num       (num),
      .valid     (valid),
      .err       (err),
      .busy      (busy)
   );

   always #5 hwclk = ~hwclk;

   // cyc equals the number of rising edges seen so far.
   always @(posedge hwclk) cyc <= cyc + 1;

   always @(negedge hwclk) begin
      if (chk_en) begin
         if (num_set[cyc] >= 0) model_num = 4'(num_set[cyc]);
         n_vec++;
         if (valid !== exp_valid[cyc] || err !== exp_err[cyc] ||
             busy !== exp_busy[cyc] || num !== model_num) begin
            n_bad++;
            $display("FAIL cycle %0d valid/err/busy/num got %0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                     cyc, valid, err, busy, num,
                     exp_valid[cyc], exp_err[cyc], exp_busy[cyc], model_num);
         end
      end
   end

   task automatic tick();
      @(posedge hwclk);
      #1;
   endtask

   task automatic set_pins(input logic [2:0] d, input logic c);
      {in2, in1, in0} = d;
      controlIn       = c;
   endtask

   task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   // Strobe of len cycles; data is d0, switching to d1 at strobe cycle chg.
   // Outcomes are decided from the frame as a whole: length class, whether
   // the data held still, and whether the digit is the invalid code.
   task automatic frame(input logic [2:0] d0, input logic [2:0] d1,
                        input int chg, input int len, input int gap);
      int k0;
      int fin;
      k0  = cyc + 1;
      fin = k0 + len + 2 + ((len == MAXH) ? 1 : 0);
      for (int e = k0 + 2; e < fin; e++) exp_busy[e] = 1'b1;
      if (len >= MAXH) begin
         exp_err[k0 + MAXH + 2] = 1'b1;
      end else if (len >= MINH) begin
         if ((chg > 0 && chg < len && d1 != d0) || d0 == 3'd7) begin
            exp_err[k0 + len + 2] = 1'b1;
         end else begin
            exp_valid[k0 + len + 2] = 1'b1;
            num_set[k0 + len + 2]   = int'(d0);
         end
      end
      for (int i = 0; i < len; i++) begin
         set_pins((i >= chg) ? d1 : d0, 1'b1);
         tick();
      end
      controlIn = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic abort_frame(input logic [2:0] d, input int n);
      int k0;
      k0 = cyc + 1;
      for (int e = k0 + 2; e <= k0 + n - 2; e++) exp_busy[e] = 1'b1;
      for (int i = 0; i < n; i++) begin
         set_pins(d, 1'b1);
         tick();
      end
      rst          = 1'b1;
      controlIn    = 1'b0;
      num_set[cyc] = 0;
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) num_set[i] = -1;
      chk_en = 1'b1;
      rst    = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      check_lit("reset_num", num, 4'd0);

      frame(3'd5, 3'd5, 20, 20, 8);
      check_lit("num_after_d5", num, 4'd5);
      frame(3'd3, 3'd3, 6, 6, 8);
      check_lit("num_after_glitch", num, 4'd5);
      frame(3'd2, 3'd6, 12, 20, 8);
      check_lit("num_after_unstable", num, 4'd5);
      frame(3'd4, 3'd0, 3, 20, 8);
      frame(3'd4, 3'd4, 60, 60, 8);
      frame(3'd7, 3'd7, 20, 20, 8);
      check_lit("num_after_code7", num, 4'd5);
      frame(3'd1, 3'd1, 9, 9, 8);
      frame(3'd3, 3'd3, 10, 10, 8);
      check_lit("num_after_min_hold", num, 4'd3);
      frame(3'd1, 3'd1, 39, 39, 1);
      frame(3'd2, 3'd2, 12, 12, 8);
      check_lit("num_after_back_to_back", num, 4'd2);
      frame(3'd5, 3'd5, 40, 40, 8);
      check_lit("num_after_timeout_edge", num, 4'd2);
      abort_frame(3'd1, 15);
      check_lit("num_after_abort", num, 4'd0);
      frame(3'd6, 3'd6, 20, 20, 8);
      check_lit("num_after_d6", num, 4'd6);

      repeat (4) tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
